id_ex_hazard_ctrl: RTL and testbench

Hazard controller that drives the stall and flush controls of the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards by comparing ID source registers against the load destination in EX.
- Detects control redirects (taken branch or jump resolved in EX).
- Sequences stall bubbles and a post-redirect flush window through a small FSM.
- Sits between the ID stage, the EX stage and the pipeline-register enable/clear inputs.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 24 ++
 rtl/id_ex_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the ID/EX hazard controller: FSM states, stall counter
// width and the packed pipeline-control bundle.
package hazard_pkg;

  localparam logic [1:0] RUN   = 2'b00;
  localparam logic [1:0] STALL = 2'b01;
  localparam logic [1:0] FLUSH = 2'b10;

  localparam int STALL_CNT_W = 3;
  localparam int REG_ZERO    = 0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN      = ctrl_t'(4'b1100);
  localparam ctrl_t CTRL_STALL    = ctrl_t'(4'b0001);
  localparam ctrl_t CTRL_REDIRECT = ctrl_t'(4'b1111);
  localparam ctrl_t CTRL_RESET    = ctrl_t'(4'b0011);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Register zero never creates a hazard.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_id,
  input  logic [ADDR_W-1:0] rt_id,
  input  logic              uses_rt_id,
  input  logic              mem_read_ex,
  input  logic [ADDR_W-1:0] rt_ex,
  output logic              load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (rt_ex == rs_id);
  assign rt_match = uses_rt_id & (rt_ex == rt_id);

  assign load_use = mem_read_ex & (rt_ex != ADDR_W'(REG_ZERO)) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Stall/flush controller for the PC, IF/ID and ID/EX registers.
// Define HAZARD_PERF_CNT_EN to add saturating stall_cnt/flush_cnt outputs.
module id_ex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs_ID,
  input  logic [REG_ADDR_W-1:0] rt_ID,
  input  logic                  uses_rt_ID,
  input  logic                  MemRead_EX,
  input  logic [REG_ADDR_W-1:0] rt_EX,
  input  logic                  branch_taken_EX,
  input  logic                  Jump_EX,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            hazard_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
`endif
);

  localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(STALL_CYCLES - 1);

  logic                   load_use;
  logic                   redirect;
  logic [1:0]             state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t                  ctrl;
  ctrl_t                  ctrl_out;

  load_use_detect #(
    .ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .rs_id       (rs_ID),
    .rt_id       (rt_ID),
    .uses_rt_id  (uses_rt_ID),
    .mem_read_ex (MemRead_EX),
    .rt_ex       (rt_EX),
    .load_use    (load_use)
  );

  assign redirect = branch_taken_EX | Jump_EX;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_RUN;
    case (state_q)
      RUN: begin
        if (redirect) begin
          ctrl    = CTRL_REDIRECT;
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (load_use) begin
          ctrl = CTRL_STALL;
          if (STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = STALL_RELOAD;
          end
        end
      end
      STALL: begin
        if (redirect) begin
          ctrl    = CTRL_REDIRECT;
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          ctrl = CTRL_STALL;
          if (cnt_q <= STALL_CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - STALL_CNT_W'(1);
          end
        end
      end
      // EX holds a bubble after a redirect, so its hazard inputs are meaningless.
      FLUSH: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset freezes the front end and bubbles ID/EX without waiting for a clock.
  assign ctrl_out     = rst_n ? ctrl : CTRL_RESET;
  assign pc_write     = ctrl_out.pc_write;
  assign if_id_write  = ctrl_out.if_id_write;
  assign if_id_flush  = ctrl_out.if_id_flush;
  assign id_ex_flush  = ctrl_out.id_ex_flush;
  assign hazard_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic        stall_cycle;
  logic        redirect_cycle;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  assign stall_cycle    = ctrl_out.id_ex_flush & ~ctrl_out.if_id_flush;
  assign redirect_cycle = rst_n & ctrl.if_id_flush & ctrl.id_ex_flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_cycle && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (redirect_cycle && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl: one instance with STALL_CYCLES=1 and one
// with STALL_CYCLES=3 share the same ID/EX stimulus.
module tb_id_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_ID, rt_ID, rt_EX;
  logic       uses_rt_ID, MemRead_EX, branch_taken_EX, Jump_EX;

  logic       pc_write1, if_id_write1, if_id_flush1, id_ex_flush1;
  logic       pc_write3, if_id_write3, if_id_flush3, id_ex_flush3;
  logic [1:0] hs1, hs3;
  logic [5:0] o1, o3;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, hazard_state}
  assign o1 = {pc_write1, if_id_write1, if_id_flush1, id_ex_flush1, hs1};
  assign o3 = {pc_write3, if_id_write3, if_id_flush3, id_ex_flush3, hs3};

  id_ex_hazard_ctrl #(.STALL_CYCLES(1), .REG_ADDR_W(5)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .rs_ID (rs_ID), .rt_ID (rt_ID), .uses_rt_ID (uses_rt_ID),
    .MemRead_EX (MemRead_EX), .rt_EX (rt_EX), .branch_taken_EX (branch_taken_EX),
    .Jump_EX (Jump_EX), .pc_write (pc_write1), .if_id_write (if_id_write1),
    .if_id_flush (if_id_flush1), .id_ex_flush (id_ex_flush1), .hazard_state (hs1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt (stall_cnt1), .flush_cnt (flush_cnt1)
`endif
  );

  id_ex_hazard_ctrl #(.STALL_CYCLES(3), .REG_ADDR_W(5)) u_dut3 (
    .clk (clk), .rst_n (rst_n), .rs_ID (rs_ID), .rt_ID (rt_ID), .uses_rt_ID (uses_rt_ID),
    .MemRead_EX (MemRead_EX), .rt_EX (rt_EX), .branch_taken_EX (branch_taken_EX),
    .Jump_EX (Jump_EX), .pc_write (pc_write3), .if_id_write (if_id_write3),
    .if_id_flush (if_id_flush3), .id_ex_flush (id_ex_flush3), .hazard_state (hs3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt (stall_cnt3), .flush_cnt (flush_cnt3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rs_ID = 5'd0; rt_ID = 5'd0; rt_EX = 5'd0;
    uses_rt_ID = 1'b0; MemRead_EX = 1'b0; branch_taken_EX = 1'b0; Jump_EX = 1'b0;
  endtask

  task automatic drive_load_use_rs8();
    MemRead_EX = 1'b1; rt_EX = 5'd8; rs_ID = 5'd8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    drive_load_use_rs8();
    #3;
    tests_run++; if (o1 !== 6'b001100) begin tests_failed++; $display("FAIL reset_hold_d1: got %b want %b", o1, 6'b001100); end
    tests_run++; if (o3 !== 6'b001100) begin tests_failed++; $display("FAIL reset_hold_d3: got %b want %b", o3, 6'b001100); end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    tick();
    tests_run++; if (o1 !== 6'b110000) begin tests_failed++; $display("FAIL reset_idle_d1: got %b want %b", o1, 6'b110000); end
    tests_run++; if (o3 !== 6'b110000) begin tests_failed++; $display("FAIL reset_idle_d3: got %b want %b", o3, 6'b110000); end
  endtask

  task automatic test_load_use();
    drive_load_use_rs8();
    #1;
    tests_run++; if (o1 !== 6'b000100) begin tests_failed++; $display("FAIL lu_c0_d1: got %b want %b", o1, 6'b000100); end
    tests_run++; if (o3 !== 6'b000100) begin tests_failed++; $display("FAIL lu_c0_d3: got %b want %b", o3, 6'b000100); end
    tick();
    drive_idle();
    #1;
    tests_run++; if (o1 !== 6'b110000) begin tests_failed++; $display("FAIL lu_c1_d1: got %b want %b", o1, 6'b110000); end
    tests_run++; if (o3 !== 6'b000101) begin tests_failed++; $display("FAIL lu_c1_d3: got %b want %b", o3, 6'b000101); end
    tick();
    tests_run++; if (o3 !== 6'b000101) begin tests_failed++; $display("FAIL lu_c2_d3: got %b want %b", o3, 6'b000101); end
    tick();
    tests_run++; if (o3 !== 6'b110000) begin tests_failed++; $display("FAIL lu_c3_d3: got %b want %b", o3, 6'b110000); end
  endtask

  task automatic test_zero_and_rt_gating();
    MemRead_EX = 1'b1; rt_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0; uses_rt_ID = 1'b1;
    #1;
    tests_run++; if (o1 !== 6'b110000) begin tests_failed++; $display("FAIL zero_reg_d1: got %b want %b", o1, 6'b110000); end
    rt_EX = 5'd9; rt_ID = 5'd9; rs_ID = 5'd3; uses_rt_ID = 1'b0;
    #1;
    tests_run++; if (o1 !== 6'b110000) begin tests_failed++; $display("FAIL rt_unused_d1: got %b want %b", o1, 6'b110000); end
    uses_rt_ID = 1'b1;
    #1;
    tests_run++; if (o1 !== 6'b000100) begin tests_failed++; $display("FAIL rt_used_d1: got %b want %b", o1, 6'b000100); end
    tick();
    drive_idle();
    tick();
    tick();
    tests_run++; if (o3 !== 6'b110000) begin tests_failed++; $display("FAIL rt_settle_d3: got %b want %b", o3, 6'b110000); end
  endtask

  task automatic test_redirect();
    branch_taken_EX = 1'b1;
    #1;
    tests_run++; if (o1 !== 6'b111100) begin tests_failed++; $display("FAIL br_c0_d1: got %b want %b", o1, 6'b111100); end
    tick();
    branch_taken_EX = 1'b0;
    drive_load_use_rs8();
    #1;
    tests_run++; if (o1 !== 6'b110010) begin tests_failed++; $display("FAIL br_flush_d1: got %b want %b", o1, 6'b110010); end
    tests_run++; if (o3 !== 6'b110010) begin tests_failed++; $display("FAIL br_flush_d3: got %b want %b", o3, 6'b110010); end
    tick();
    drive_idle();
    #1;
    tests_run++; if (o1 !== 6'b110000) begin tests_failed++; $display("FAIL br_after_d1: got %b want %b", o1, 6'b110000); end
  endtask

  task automatic test_priority();
    Jump_EX = 1'b1;
    drive_load_use_rs8();
    #1;
    tests_run++; if (o1 !== 6'b111100) begin tests_failed++; $display("FAIL jmp_lu_d1: got %b want %b", o1, 6'b111100); end
    tests_run++; if (o3 !== 6'b111100) begin tests_failed++; $display("FAIL jmp_lu_d3: got %b want %b", o3, 6'b111100); end
    tick();
    drive_idle();
    #1;
    tests_run++; if (o3 !== 6'b110010) begin tests_failed++; $display("FAIL jmp_flush_d3: got %b want %b", o3, 6'b110010); end
    tick();
    drive_load_use_rs8();
    #1;
    tests_run++; if (o3 !== 6'b000100) begin tests_failed++; $display("FAIL inj_c0_d3: got %b want %b", o3, 6'b000100); end
    tick();
    drive_idle();
    branch_taken_EX = 1'b1;
    #1;
    tests_run++; if (o3 !== 6'b111101) begin tests_failed++; $display("FAIL inj_redir_d3: got %b want %b", o3, 6'b111101); end
    tick();
    branch_taken_EX = 1'b0;
    #1;
    tests_run++; if (o3 !== 6'b110010) begin tests_failed++; $display("FAIL inj_flush_d3: got %b want %b", o3, 6'b110010); end
    tick();
    tests_run++; if (o3 !== 6'b110000) begin tests_failed++; $display("FAIL inj_run_d3: got %b want %b", o3, 6'b110000); end
    tick();
    tests_run++; if (o3 !== 6'b110000) begin tests_failed++; $display("FAIL inj_stay_d3: got %b want %b", o3, 6'b110000); end
  endtask

  task automatic test_reset_mid_stall();
    drive_load_use_rs8();
    tick();
    drive_idle();
    #1;
    tests_run++; if (o3 !== 6'b000101) begin tests_failed++; $display("FAIL mid_stall_d3: got %b want %b", o3, 6'b000101); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (o3 !== 6'b001100) begin tests_failed++; $display("FAIL mid_reset_d3: got %b want %b", o3, 6'b001100); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++; if (o3 !== 6'b110000) begin tests_failed++; $display("FAIL mid_release_d3: got %b want %b", o3, 6'b110000); end
    tick();
    tests_run++; if (o3 !== 6'b110000) begin tests_failed++; $display("FAIL mid_first_edge_d3: got %b want %b", o3, 6'b110000); end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive_idle();
    tick();
    for (int h = 0; h < 2; h++) begin
      drive_load_use_rs8();
      tick();
      drive_idle();
      tick();
      tick();
      tick();
    end
    branch_taken_EX = 1'b1;
    tick();
    branch_taken_EX = 1'b0;
    tick();
    tests_run++; if (stall_cnt1 !== 16'd2) begin tests_failed++; $display("FAIL perf_stall_d1: got %0d want %0d", stall_cnt1, 2); end
    tests_run++; if (flush_cnt1 !== 16'd1) begin tests_failed++; $display("FAIL perf_flush_d1: got %0d want %0d", flush_cnt1, 1); end
    tests_run++; if (stall_cnt3 !== 16'd6) begin tests_failed++; $display("FAIL perf_stall_d3: got %0d want %0d", stall_cnt3, 6); end
    tests_run++; if (flush_cnt3 !== 16'd1) begin tests_failed++; $display("FAIL perf_flush_d3: got %0d want %0d", flush_cnt3, 1); end
    drive_load_use_rs8();
    repeat (65540) @(posedge clk);
    #1;
    drive_idle();
    tests_run++; if (stall_cnt1 !== 16'hFFFF) begin tests_failed++; $display("FAIL perf_sat_d1: got %h want %h", stall_cnt1, 16'hFFFF); end
    tests_run++; if (stall_cnt3 !== 16'hFFFF) begin tests_failed++; $display("FAIL perf_sat_d3: got %h want %h", stall_cnt3, 16'hFFFF); end
    tests_run++; if (flush_cnt1 !== 16'd1) begin tests_failed++; $display("FAIL perf_flush_hold_d1: got %0d want %0d", flush_cnt1, 1); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_zero_and_rt_gating();
    test_redirect();
    test_priority();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
